// File: rtl/silencer_pkg.sv
// Shared silencer definitions: burst sequencing states and stream widths,
// common to the stream source and the interpolator.
package silencer_pkg;

    localparam int DEPTH_DEFAULT = 249;
    localparam int ADDR_W        = 8;
    localparam int INTENSITY_W   = 16;
    localparam int PHASE_W       = 8;
    localparam int MAX_LATENCY   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/silencer_stream_source_valid_pipe.sv
// 1-bit delay line that follows the address issue strobe through the
// external memory read latency; cleared synchronously.
module valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;
    logic [DEPTH:0]   nxt;

    assign nxt  = {sr, din};
    assign dout = sr[DEPTH-1];

    always_ff @(posedge clk) begin
        if (clr) begin
            sr <= '0;
        end else begin
            sr <= nxt[DEPTH-1:0];
        end
    end

endmodule

// File: rtl/silencer_stream_source.sv
// Walks the external parameter memory once per UPDATE and streams the
// read data, with one-deep request queueing and a sticky drop flag.
module silencer_stream_source
    import silencer_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int READ_LATENCY = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   UPDATE,
    output logic [ADDR_W-1:0]      ADDR,
    input  logic [INTENSITY_W-1:0] RD_INTENSITY,
    input  logic [PHASE_W-1:0]     RD_PHASE,
    output logic [INTENSITY_W-1:0] INTENSITY_OUT,
    output logic [PHASE_W-1:0]     PHASE_OUT,
    output logic                   DOUT_VALID,
    output logic                   BUSY,
    output logic                   OVERRUN
);

    generate
        if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("silencer_stream_source: DEPTH must be 1..256");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > MAX_LATENCY) begin : g_bad_lat
            $error("silencer_stream_source: READ_LATENCY must be 1..4");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(READ_LATENCY);

    state_e     state;
    logic       issue;
    logic       pending;
    logic [2:0] drain_cnt;
    logic       rd_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ADDR      <= '0;
            issue     <= 1'b0;
            BUSY      <= 1'b0;
            pending   <= 1'b0;
            OVERRUN   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (UPDATE) begin
                        state <= RUN;
                        ADDR  <= '0;
                        issue <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                end
                RUN: begin
                    if (ADDR == LAST_ADDR) begin
                        state     <= DRAIN;
                        issue     <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        ADDR <= ADDR + 8'd1;
                    end
                    if (UPDATE) begin
                        if (pending) begin
                            OVERRUN <= 1'b1;
                        end else begin
                            pending <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        // last word is on the outputs now; an UPDATE in this
                        // cycle counts as queued and starts straight away
                        pending <= 1'b0;
                        if (pending && UPDATE) begin
                            OVERRUN <= 1'b1;
                        end
                        if (pending || UPDATE) begin
                            state <= RUN;
                            ADDR  <= '0;
                            issue <= 1'b1;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                        if (UPDATE) begin
                            if (pending) begin
                                OVERRUN <= 1'b1;
                            end else begin
                                pending <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    issue <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    valid_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_valid_pipe (
        .clk (CLK),
        .clr (RST),
        .din (issue),
        .dout(rd_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT_VALID    <= 1'b0;
            INTENSITY_OUT <= '0;
            PHASE_OUT     <= '0;
        end else begin
            DOUT_VALID <= rd_valid;
            if (rd_valid) begin
                INTENSITY_OUT <= RD_INTENSITY;
                PHASE_OUT     <= RD_PHASE;
            end
        end
    end

endmodule

// File: tb/tb_silencer_stream_source.sv
// Three configurations of the stream source against a cycle-timeline model
// of bursts, queued requests and overrun, with random memory and stimulus.
module tb_silencer_stream_source;

    localparam int N    = 3;
    localparam int NCYC = 12000;
    localparam int DEP[N] = '{249, 1, 1};
    localparam int LAT[N] = '{2, 1, 4};

    logic        clk;
    logic        upd [N];
    logic        rst [N];
    logic [7:0]  addr[N];
    logic [15:0] rdi [N];
    logic [7:0]  rdp [N];
    logic [15:0] oi  [N];
    logic [7:0]  op  [N];
    logic        vl  [N];
    logic        bz  [N];
    logic        ov  [N];

    logic [15:0] mem_i[256];
    logic [7:0]  mem_p[256];
    logic [7:0]  ah[N][4];

    int checks;
    int failures;

    bit     have[N];
    longint s   [N];
    bit     pend[N];
    bit     ovr [N];
    logic [15:0] li[N];
    logic [7:0]  lp[N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    silencer_stream_source #(.DEPTH(249), .READ_LATENCY(2)) u_main (
        .CLK(clk), .RST(rst[0]), .UPDATE(upd[0]), .ADDR(addr[0]),
        .RD_INTENSITY(rdi[0]), .RD_PHASE(rdp[0]),
        .INTENSITY_OUT(oi[0]), .PHASE_OUT(op[0]),
        .DOUT_VALID(vl[0]), .BUSY(bz[0]), .OVERRUN(ov[0])
    );

    silencer_stream_source #(.DEPTH(1), .READ_LATENCY(1)) u_l1 (
        .CLK(clk), .RST(rst[1]), .UPDATE(upd[1]), .ADDR(addr[1]),
        .RD_INTENSITY(rdi[1]), .RD_PHASE(rdp[1]),
        .INTENSITY_OUT(oi[1]), .PHASE_OUT(op[1]),
        .DOUT_VALID(vl[1]), .BUSY(bz[1]), .OVERRUN(ov[1])
    );

    silencer_stream_source #(.DEPTH(1), .READ_LATENCY(4)) u_l4 (
        .CLK(clk), .RST(rst[2]), .UPDATE(upd[2]), .ADDR(addr[2]),
        .RD_INTENSITY(rdi[2]), .RD_PHASE(rdp[2]),
        .INTENSITY_OUT(oi[2]), .PHASE_OUT(op[2]),
        .DOUT_VALID(vl[2]), .BUSY(bz[2]), .OVERRUN(ov[2])
    );

    // external memory: data for the address of cycle c is valid in c+L
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            ah[i][0] <= addr[i];
            for (int j = 1; j < 4; j++) ah[i][j] <= ah[i][j-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rdi[i] = mem_i[ah[i][LAT[i]-1]];
            rdp[i] = mem_p[ah[i][LAT[i]-1]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int i, input longint c);
        longint last;
        bit busy_e, valid_e;
        longint addr_e, k;
        string t;
        last    = s[i] + LAT[i] + DEP[i];
        busy_e  = have[i] && c <= last;
        valid_e = have[i] && c >= s[i] + LAT[i] + 1 && c <= last;
        if (!have[i]) addr_e = 0;
        else addr_e = (c - s[i] > DEP[i] - 1) ? DEP[i] - 1 : c - s[i];
        if (valid_e) begin
            k = c - s[i] - LAT[i] - 1;
            li[i] = mem_i[k];
            lp[i] = mem_p[k];
        end
        t = $sformatf("u%0d@%0d", i, c);
        chk({t, ".valid"}, 32'(vl[i]), 32'(valid_e));
        chk({t, ".busy"}, 32'(bz[i]), 32'(busy_e));
        chk({t, ".addr"}, 32'(addr[i]), 32'(addr_e));
        chk({t, ".int"}, 32'(oi[i]), 32'(li[i]));
        chk({t, ".phase"}, 32'(op[i]), 32'(lp[i]));
        chk({t, ".ovr"}, 32'(ov[i]), 32'(ovr[i]));
    endtask

    task automatic model_step(input int i, input longint c, input bit u,
                              input bit r);
        longint last;
        if (r) begin
            have[i] = 0;
            pend[i] = 0;
            ovr[i]  = 0;
            li[i]   = '0;
            lp[i]   = '0;
            return;
        end
        last = s[i] + LAT[i] + DEP[i];
        if (!(have[i] && c <= last)) begin
            if (u) begin
                have[i] = 1;
                s[i]    = c + 1;
            end
        end else if (c == last) begin
            if (pend[i] || u) s[i] = c + 1;
            if (pend[i] && u) ovr[i] = 1;
            pend[i] = 0;
        end else if (u) begin
            if (pend[i]) ovr[i] = 1;
            else pend[i] = 1;
        end
    endtask

    function automatic bit directed_upd(input longint c);
        return c == 10 || c == 100 || c == 610 || c == 650 || c == 660 ||
               c == 1210 || c == 1462 || c == 1810 || c == 1950;
    endfunction

    initial begin
        bit r;
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 256; k++) begin
            mem_i[k] = 16'($urandom);
            mem_p[k] = 8'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            upd[i] = 1'b0;
            rst[i] = 1'b1;
            have[i] = 0;
            s[i] = 0;
            pend[i] = 0;
            ovr[i] = 0;
            li[i] = '0;
            lp[i] = '0;
        end
        for (longint c = 1; c <= NCYC; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) check_inst(i, c);

            if (c == 13)   chk("main_first_m1", 32'(vl[0]), 0);
            if (c == 14)   chk("main_first", 32'(vl[0]), 1);
            if (c == 14)   chk("main_word0", 32'(oi[0]), 32'(mem_i[0]));
            if (c == 114)  chk("main_word100", 32'(oi[0]), 32'(mem_i[100]));
            if (c == 262)  chk("main_last", 32'(vl[0]), 1);
            if (c == 263)  chk("b2b_addr0", 32'(addr[0]), 0);
            if (c == 263)  chk("b2b_busy", 32'(bz[0]), 1);
            if (c == 265)  chk("b2b_gap", 32'(vl[0]), 0);
            if (c == 266)  chk("b2b_first", 32'(vl[0]), 1);
            if (c == 660)  chk("ovr_before", 32'(ov[0]), 0);
            if (c == 661)  chk("ovr_set", 32'(ov[0]), 1);
            if (c == 1463) chk("coinc_addr0", 32'(addr[0]), 0);
            if (c == 1901) chk("rst_valid", 32'(vl[0]), 0);
            if (c == 1901) chk("rst_busy", 32'(bz[0]), 0);
            if (c == 1901) chk("rst_addr", 32'(addr[0]), 0);
            if (c == 2202) chk("post_rst_last", 32'(vl[0]), 1);
            if (c == 2203) chk("post_rst_end", 32'(vl[0]), 0);
            if (c == 12)   chk("l1_early", 32'(vl[1]), 0);
            if (c == 13)   chk("l1_word", 32'(vl[1]), 1);
            if (c == 13)   chk("l1_data", 32'(op[1]), 32'(mem_p[0]));
            if (c == 14)   chk("l1_single", 32'(vl[1]), 0);
            if (c == 15)   chk("l4_early", 32'(vl[2]), 0);
            if (c == 16)   chk("l4_word", 32'(vl[2]), 1);
            if (c == 16)   chk("l4_data", 32'(oi[2]), 32'(mem_i[0]));
            if (c == 17)   chk("l4_single", 32'(vl[2]), 0);

            if (c < 2300) begin
                r = (c <= 3) || (c == 1900);
                for (int i = 0; i < N; i++) upd[i] = directed_upd(c);
            end else begin
                r = ($urandom_range(0, 2999) == 0);
                upd[0] = ($urandom_range(0, 149) == 0);
                upd[1] = ($urandom_range(0, 3) == 0);
                upd[2] = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < N; i++) begin
                rst[i] = r;
                model_step(i, c, upd[i], r);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
